// File: rtl/gerenciador_param_if.sv
// HPS PIO words plus the coprocessor operand/result bundle used by gerenciador_param.
// The manager connects through the master modport; the HPS/coprocessor side uses slave.
interface gerenciador_param_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_DIM = 5
);
  localparam int unsigned FlatW = MAX_DIM * MAX_DIM * DATA_W;

  logic [31:0]      entrada;
  logic [31:0]      saida;
  logic             cop_start;
  logic [2:0]       cop_op;
  logic [1:0]       cop_tam;
  logic [FlatW-1:0] cop_a;
  logic [FlatW-1:0] cop_b;
  logic [FlatW-1:0] cop_result;
  logic             cop_overflow;
  logic             cop_done;

  modport master (
    input  entrada, cop_result, cop_overflow, cop_done,
    output saida, cop_start, cop_op, cop_tam, cop_a, cop_b
  );

  modport slave (
    output entrada, cop_result, cop_overflow, cop_done,
    input  saida, cop_start, cop_op, cop_tam, cop_a, cop_b
  );
endinterface

// File: rtl/gerenciador_param.sv
// HPS<->coprocessor transfer manager: loads two NxN matrices over a 4-phase handshake,
// runs one coprocessor operation with a timeout, and returns the packed result words.
module gerenciador_param #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned MAX_DIM      = 5,
  parameter int unsigned OUT_PER_WORD = 3,
  parameter int unsigned TIMEOUT_CYC  = 1024
) (
  input logic                 clk,
  input logic                 reset_n,
  gerenciador_param_if.master bus
);
  localparam int unsigned NElem = MAX_DIM * MAX_DIM;
  localparam int unsigned FlatW = NElem * DATA_W;
  localparam int unsigned IdxW  = $clog2(NElem + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StSend} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;     // element index in LOAD, word index in SEND
  logic [IdxW-1:0]  elems_q, elems_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [FlatW-1:0] a_q, a_d;
  logic [FlatW-1:0] b_q, b_d;
  logic [FlatW-1:0] res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       tam_q, tam_d;
  logic             start_q, start_d;
  logic             in_ack_q, in_ack_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             tmo_q, tmo_d;
  logic [23:0]      lanes_q, lanes_d;

  logic             in_req, out_ack, soft_rst;
  logic [IdxW-1:0]  words;
  logic             unused_bits;

  assign in_req   = bus.entrada[31];
  assign out_ack  = bus.entrada[30];
  assign soft_rst = bus.entrada[29];
  assign unused_bits = ^{bus.entrada[28:21], bus.entrada[15:0]};

  // E = N*N with N = tam+2 clamped to MAX_DIM.
  function automatic logic [IdxW-1:0] elem_count(input logic [1:0] tam);
    int unsigned n;
    n = 32'(tam) + 32'd2;
    if (n > MAX_DIM) n = MAX_DIM;
    return IdxW'(n * n);
  endfunction

  function automatic logic [23:0] pack_word(input logic [FlatW-1:0] rb,
                                            input logic [IdxW-1:0] w);
    logic [23:0] word;
    int unsigned k;
    word = '0;
    for (int unsigned j = 0; j < 3; j++) begin
      k = 32'(w) * OUT_PER_WORD + j;
      if (j < OUT_PER_WORD && k < NElem) word[8*j +: 8] = 8'(rb[k*DATA_W +: DATA_W]);
    end
    return word;
  endfunction

  assign words = IdxW'((32'(elems_q) + OUT_PER_WORD - 1) / OUT_PER_WORD);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    elems_d   = elems_q;
    tmo_cnt_d = tmo_cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    op_d      = op_q;
    tam_d     = tam_q;
    start_d   = 1'b0;
    in_ack_d  = in_ack_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    tmo_d     = tmo_q;
    lanes_d   = lanes_q;

    unique case (state_q)
      StIdle: begin
        if (in_req) begin
          state_d = StLoad;
          busy_d  = 1'b1;
          idx_d   = '0;
        end
      end
      StLoad: begin
        if (idx_q != '0 && idx_q == elems_q && !in_ack_q) begin
          state_d = StStart;
          idx_d   = '0;
        end else if (in_req && !in_ack_q) begin
          // Element 0 fixes E and clears stale elements from a larger previous transfer.
          if (idx_q == '0) begin
            elems_d = elem_count(bus.entrada[20:19]);
            a_d     = '0;
            b_d     = '0;
          end
          a_d[32'(idx_q)*DATA_W +: DATA_W] = bus.entrada[DATA_W-1:0];
          b_d[32'(idx_q)*DATA_W +: DATA_W] = bus.entrada[8 +: DATA_W];
          op_d     = bus.entrada[18:16];
          tam_d    = bus.entrada[20:19];
          in_ack_d = 1'b1;
        end else if (!in_req && in_ack_q) begin
          in_ack_d = 1'b0;
          idx_d    = idx_q + 1'b1;
        end
      end
      StStart: begin
        start_d   = 1'b1;
        tmo_cnt_d = '0;
        tmo_d     = 1'b0;
        state_d   = StWait;
      end
      StWait: begin
        if (bus.cop_done) begin
          for (int unsigned k = 0; k < NElem; k++) begin
            if (k < 32'(elems_q)) res_d[k*DATA_W +: DATA_W] = bus.cop_result[k*DATA_W +: DATA_W];
            else                  res_d[k*DATA_W +: DATA_W] = '0;
          end
          ovf_d   = bus.cop_overflow;
          idx_d   = '0;
          state_d = StSend;
        end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1)) begin
          tmo_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StSend: begin
        if (!valid_q && !out_ack) begin
          if (idx_q == words) begin
            busy_d  = 1'b0;
            ovf_d   = 1'b0;
            lanes_d = '0;
            state_d = StIdle;
          end else begin
            lanes_d = pack_word(res_q, idx_q);
            valid_d = 1'b1;
          end
        end else if (valid_q && out_ack) begin
          valid_d = 1'b0;
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Soft reset overrides everything decided above.
    if (soft_rst) begin
      state_d   = StIdle;
      idx_d     = '0;
      elems_d   = '0;
      tmo_cnt_d = '0;
      a_d       = '0;
      b_d       = '0;
      res_d     = '0;
      op_d      = 3'b111;
      tam_d     = '0;
      start_d   = 1'b0;
      in_ack_d  = 1'b0;
      valid_d   = 1'b0;
      ovf_d     = 1'b0;
      busy_d    = 1'b0;
      tmo_d     = 1'b0;
      lanes_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      elems_q   <= '0;
      tmo_cnt_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      op_q      <= 3'b111;
      tam_q     <= '0;
      start_q   <= 1'b0;
      in_ack_q  <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      tmo_q     <= 1'b0;
      lanes_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      elems_q   <= elems_d;
      tmo_cnt_q <= tmo_cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      op_q      <= op_d;
      tam_q     <= tam_d;
      start_q   <= start_d;
      in_ack_q  <= in_ack_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      tmo_q     <= tmo_d;
      lanes_q   <= lanes_d;
    end
  end

  assign bus.saida     = {in_ack_q, valid_q, ovf_q, busy_q, tmo_q, 3'b000, lanes_q};
  assign bus.cop_start = start_q;
  assign bus.cop_op    = op_q;
  assign bus.cop_tam   = tam_q;
  assign bus.cop_a     = a_q;
  assign bus.cop_b     = b_q;
endmodule

// File: tb/tb_gerenciador_param.sv
// Self-checking bench for gerenciador_param: table of directed transfers plus random transfers
// checked against a matrix-level reference model.
module tb_gerenciador_param;
  localparam int unsigned FW = 200;

  typedef struct {
    logic [1:0]  tam;
    logic [2:0]  op;
    bit          ovf;
    bit          hold;
    int          mode;      // 0 normal, 1 soft rst in LOAD, 2 soft rst in SEND, 3 timeout, 4 hard rst
    int          abort_at;
    int          delay;
    bit          det;
    logic [23:0] exp_first;
    logic [23:0] exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gerenciador_param_if #(.DATA_W(8), .MAX_DIM(5)) bus ();

  gerenciador_param #(
    .DATA_W(8), .MAX_DIM(5), .OUT_PER_WORD(3), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_pass = 0;
  int n_total = 0;
  bit exp_tmo = 1'b0;
  logic [7:0] da[25];
  logic [7:0] db[25];
  logic [7:0] dc[25];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_saida(input int bitn, input logic val, input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.saida[bitn] === val) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_in_time"}, FW'(ok), FW'(1));
  endtask

  task automatic run_xfer(input vec_t v);
    int n, e, nw;
    bit ok;
    logic [FW-1:0] ea, eb, cres;
    logic [23:0] wexp[9];

    // Reference model: matrix-level view of what must reach the coprocessor and the HPS.
    n = int'(v.tam) + 2;
    if (n > 5) n = 5;
    e  = n * n;
    nw = (e + 2) / 3;
    ea = '0;
    eb = '0;
    cres = '0;
    for (int w = 0; w < 9; w++) wexp[w] = '0;
    for (int k = 0; k < 25; k++) cres[k*8 +: 8] = dc[k];
    for (int k = 0; k < e; k++) begin
      ea[k*8 +: 8] = da[k];
      eb[k*8 +: 8] = db[k];
      wexp[k/3][8*(k%3) +: 8] = dc[k];
    end

    for (int i = 0; i < e; i++) begin
      bus.entrada = {1'b1, 2'b00, 8'h00, v.tam, v.op, db[i], da[i]};
      wait_saida(31, 1'b1, "in_ack_rise", ok);
      if (!ok) return;
      if (i == 0) begin
        chk("busy_in_load", FW'(bus.saida[28]), FW'(1));
        chk("tmo_held_in_load", FW'(bus.saida[27]), FW'(exp_tmo));
      end
      if (v.mode == 1 && i == v.abort_at) begin
        bus.entrada = 32'h2000_0000;
        step();
        chk("srst_load_saida", FW'(bus.saida), FW'(0));
        chk("srst_load_op", FW'(bus.cop_op), FW'(3'b111));
        chk("srst_load_tam", FW'(bus.cop_tam), FW'(0));
        chk("srst_load_a", bus.cop_a, FW'(0));
        bus.entrada = '0;
        step();
        chk("srst_load_idle", FW'(bus.saida), FW'(0));
        exp_tmo = 1'b0;
        return;
      end
      if (v.hold && i == 1) begin
        bus.entrada[7:0] = ~da[i];  // a re-latch during the hold would corrupt element 1
        repeat (10) step();
        chk("in_ack_held", FW'(bus.saida[31]), FW'(1));
      end
      bus.entrada = '0;
      wait_saida(31, 1'b0, "in_ack_fall", ok);
      if (!ok) return;
    end

    step();
    chk("start_not_early", FW'(bus.cop_start), FW'(0));
    step();
    chk("start_pulse", FW'(bus.cop_start), FW'(1));
    chk("tmo_clear_at_start", FW'(bus.saida[27]), FW'(0));
    exp_tmo = 1'b0;
    chk("cop_a", bus.cop_a, ea);
    chk("cop_b", bus.cop_b, eb);
    chk("cop_op", FW'(bus.cop_op), FW'(v.op));
    chk("cop_tam", FW'(bus.cop_tam), FW'(v.tam));
    step();
    chk("start_single", FW'(bus.cop_start), FW'(0));

    if (v.mode == 3) begin
      for (int k = 2; k <= 16; k++) begin
        step();
        if (k < 16) chk("wait_before_tmo", FW'(bus.saida[28:27]), FW'(2'b10));
        else        chk("timeout_saida", FW'(bus.saida), FW'(32'h0800_0000));
      end
      exp_tmo = 1'b1;
      return;
    end

    if (v.mode == 4) begin
      step();
      step();
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_saida", FW'(bus.saida), FW'(0));
      chk("async_rst_op", FW'(bus.cop_op), FW'(3'b111));
      chk("async_rst_a", bus.cop_a, FW'(0));
      @(posedge clk);
      #3 reset_n = 1'b1;
      step();
      bus.cop_result = cres;
      bus.cop_done = 1'b1;
      step();
      bus.cop_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
        step();
        chk("done_after_rst_ignored", FW'(bus.saida), FW'(0));
      end
      exp_tmo = 1'b0;
      return;
    end

    repeat (v.delay) step();
    bus.cop_result   = cres;
    bus.cop_overflow = v.ovf;
    bus.cop_done     = 1'b1;
    step();
    bus.cop_done     = 1'b0;
    bus.cop_overflow = 1'b0;
    bus.cop_result   = ~cres;
    chk("valid_not_early", FW'(bus.saida[30]), FW'(0));
    step();
    chk("valid_latency", FW'(bus.saida[30]), FW'(1));

    for (int w = 0; w < nw; w++) begin
      if (w > 0) begin
        wait_saida(30, 1'b1, "out_valid_rise", ok);
        if (!ok) return;
      end
      chk($sformatf("word%0d", w), FW'(bus.saida[23:0]), FW'(wexp[w]));
      chk("ovf_in_send", FW'(bus.saida[29]), FW'(v.ovf));
      chk("busy_in_send", FW'(bus.saida[28]), FW'(1));
      if (v.det && v.mode == 0 && w == 0)
        chk("table_first_word", FW'(bus.saida[23:0]), FW'(v.exp_first));
      if (v.det && v.mode == 0 && w == nw - 1)
        chk("table_last_word", FW'(bus.saida[23:0]), FW'(v.exp_last));
      if (v.mode == 2 && w == v.abort_at) begin
        bus.entrada = 32'h2000_0000;
        step();
        chk("srst_send_saida", FW'(bus.saida), FW'(0));
        chk("srst_send_a", bus.cop_a, FW'(0));
        bus.entrada = '0;
        step();
        chk("srst_send_idle", FW'(bus.saida), FW'(0));
        return;
      end
      bus.entrada = 32'h4000_0000;
      wait_saida(30, 1'b0, "out_valid_fall", ok);
      if (!ok) return;
      if (v.hold && w == 1) begin
        repeat (10) step();
        chk("no_word_while_ack_held", FW'(bus.saida[30]), FW'(0));
      end
      bus.entrada = '0;
    end
    step();
    chk("idle_after_send", FW'(bus.saida), FW'(0));
  endtask

  initial begin
    vec_t rv;
    bus.entrada      = '0;
    bus.cop_result   = '0;
    bus.cop_overflow = 1'b0;
    bus.cop_done     = 1'b0;

    //           tam    op     ovf   hold  mode abort delay det   first       last
    vecs[0] = '{2'd3, 3'd0, 1'b0, 1'b0, 0,   0,    2,    1'b1, 24'h030201, 24'h000019};
    vecs[1] = '{2'd0, 3'd5, 1'b0, 1'b0, 0,   0,    0,    1'b1, 24'h030201, 24'h000004};
    vecs[2] = '{2'd1, 3'd2, 1'b1, 1'b1, 0,   0,    5,    1'b1, 24'h030201, 24'h090807};
    vecs[3] = '{2'd2, 3'd3, 1'b0, 1'b0, 3,   0,    0,    1'b1, 24'h000000, 24'h000000};
    vecs[4] = '{2'd2, 3'd1, 1'b0, 1'b0, 0,   0,    3,    1'b1, 24'h030201, 24'h000010};
    vecs[5] = '{2'd3, 3'd4, 1'b0, 1'b0, 1,   7,    0,    1'b1, 24'h000000, 24'h000000};
    vecs[6] = '{2'd3, 3'd6, 1'b0, 1'b0, 0,   0,    1,    1'b1, 24'h030201, 24'h000019};
    vecs[7] = '{2'd3, 3'd0, 1'b0, 1'b0, 2,   3,    0,    1'b1, 24'h000000, 24'h000000};
    vecs[8] = '{2'd1, 3'd1, 1'b0, 1'b0, 4,   0,    0,    1'b1, 24'h000000, 24'h000000};
    vecs[9] = '{2'd0, 3'd7, 1'b1, 1'b0, 0,   0,    4,    1'b1, 24'h030201, 24'h000004};

    #12;
    chk("rst_saida", FW'(bus.saida), FW'(0));
    chk("rst_start", FW'(bus.cop_start), FW'(0));
    chk("rst_op", FW'(bus.cop_op), FW'(3'b111));
    chk("rst_tam", FW'(bus.cop_tam), FW'(0));
    chk("rst_a", bus.cop_a, FW'(0));
    chk("rst_b", bus.cop_b, FW'(0));
    reset_n = 1'b1;
    step();

    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 25; k++) begin
        da[k] = 8'(k);
        db[k] = 8'd1;
        dc[k] = 8'(k + 1);
      end
      run_xfer(vecs[t]);
      bus.entrada  = '0;
      bus.cop_done = 1'b0;
      repeat (2) step();
    end

    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 25; k++) begin
        da[k] = 8'($urandom);
        db[k] = 8'($urandom);
        dc[k] = 8'($urandom);
      end
      rv.tam       = 2'($urandom_range(0, 3));
      rv.op        = 3'($urandom_range(0, 7));
      rv.ovf       = 1'($urandom_range(0, 1));
      rv.hold      = ($urandom_range(0, 3) == 0);
      rv.mode      = 0;
      rv.abort_at  = 0;
      rv.delay     = int'($urandom_range(0, 8));
      rv.det       = 1'b0;
      rv.exp_first = '0;
      rv.exp_last  = '0;
      run_xfer(rv);
      bus.entrada  = '0;
      bus.cop_done = 1'b0;
      repeat (2) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
